// File: rtl/ycbcr422_pack.sv
// Packs 24-bit 4:4:4 YCbCr pixels into 16-bit 4:2:2 beats, {Cb,Y0} then {Cr,Y1}.
// Latency: beat A is valid the cycle after the odd pixel is accepted.
// Backpressure: s_tready drops in ODD while a pair is pending and beat B is not completing.
`timescale 1ns/1ps
module ycbcr422_pack #(
    parameter bit CHROMA_ROUND = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [23:0] s_axis_video_tdata,
    input  logic        s_axis_video_tvalid,
    output logic        s_axis_video_tready,
    input  logic        s_axis_video_tlast,
    input  logic        s_axis_video_tuser,
    output logic [15:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tlast,
    output logic        m_axis_video_tuser,
    output logic        align_err
);

    typedef struct packed {
        logic [7:0] cr;
        logic [7:0] cb;
        logic [7:0] y;
    } pix_t;

    typedef enum logic {ST_EVEN = 1'b0, ST_ODD = 1'b1} state_t;

    // 9-bit sum keeps the carry; the optional +1 gives round-half-up.
    function automatic logic [7:0] chroma_avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {8'd0, CHROMA_ROUND};
        return sum[8:1];
    endfunction

    state_t      state_q, state_d;
    pix_t        hold_q, hold_d;
    logic        hold_user_q, hold_user_d;
    // pad_q: the held pixel ended an odd-length line and waits for the pair slot to free up
    logic        pad_q, pad_d;
    logic [15:0] a_dat_q, a_dat_d;
    logic        a_user_q, a_user_d;
    logic [15:0] b_dat_q, b_dat_d;
    logic        b_last_q, b_last_d;
    logic        pair_vld_q, pair_vld_d;
    logic        beat_sel_q, beat_sel_d;   // 0 = beat A, 1 = beat B
    logic        align_err_q, align_err_d;

    logic        slot_free;
    logic        s_rdy;
    logic        s_acc;
    logic        take_even;
    logic        load_pair;
    logic        load_pad;
    pix_t        in_pix;
    pix_t        pad_src;
    logic        pad_user;

    // Next-state logic for the input FSM, hold register and output pair register
    always_comb begin
        in_pix      = pix_t'(s_axis_video_tdata);
        slot_free   = !pair_vld_q || (beat_sel_q && m_axis_video_tready);
        s_rdy       = rstn && ((state_q == ST_EVEN) || (!pad_q && slot_free));
        s_acc       = s_axis_video_tvalid && s_rdy;

        state_d     = state_q;
        hold_d      = hold_q;
        hold_user_d = hold_user_q;
        pad_d       = pad_q;
        a_dat_d     = a_dat_q;
        a_user_d    = a_user_q;
        b_dat_d     = b_dat_q;
        b_last_d    = b_last_q;
        pair_vld_d  = pair_vld_q;
        beat_sel_d  = beat_sel_q;
        align_err_d = align_err_q;
        take_even   = 1'b0;
        load_pair   = 1'b0;
        load_pad    = 1'b0;
        pad_src     = in_pix;
        pad_user    = s_axis_video_tuser;

        // Drain the pending pair: A -> B -> empty
        if (pair_vld_q && m_axis_video_tready) begin
            if (!beat_sel_q) begin
                beat_sel_d = 1'b1;
            end else begin
                pair_vld_d = 1'b0;
                beat_sel_d = 1'b0;
            end
        end

        case (state_q)
            ST_EVEN: begin
                if (s_acc) take_even = 1'b1;
            end
            ST_ODD: begin
                if (pad_q) begin
                    if (slot_free) begin
                        load_pad = 1'b1;
                        pad_src  = hold_q;
                        pad_user = hold_user_q;
                        pad_d    = 1'b0;
                        state_d  = ST_EVEN;
                    end
                end else if (s_acc) begin
                    if (s_axis_video_tuser) begin
                        // SOF in the odd slot: drop the held pixel and restart the pair
                        align_err_d = 1'b1;
                        take_even   = 1'b1;
                    end else begin
                        load_pair = 1'b1;
                        state_d   = ST_EVEN;
                    end
                end
            end
            default: state_d = ST_EVEN;
        endcase

        // An even-slot pixel either closes a 1-pixel remainder directly or is held
        if (take_even) begin
            if (s_axis_video_tlast && slot_free) begin
                load_pad = 1'b1;
                state_d  = ST_EVEN;
            end else begin
                hold_d      = in_pix;
                hold_user_d = s_axis_video_tuser;
                pad_d       = s_axis_video_tlast;
                state_d     = ST_ODD;
            end
        end

        if (load_pair) begin
            a_dat_d  = {chroma_avg(hold_q.cb, in_pix.cb), hold_q.y};
            a_user_d = hold_user_q;
            b_dat_d  = {chroma_avg(hold_q.cr, in_pix.cr), in_pix.y};
            b_last_d = s_axis_video_tlast;
        end else if (load_pad) begin
            a_dat_d  = {pad_src.cb, pad_src.y};
            a_user_d = pad_user;
            b_dat_d  = {pad_src.cr, pad_src.y};
            b_last_d = 1'b1;
        end
        if (load_pair || load_pad) begin
            pair_vld_d = 1'b1;
            beat_sel_d = 1'b0;
        end
    end

    // State registers; reset discards any held pixel and pending pair
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_EVEN;
            hold_q      <= '0;
            hold_user_q <= 1'b0;
            pad_q       <= 1'b0;
            a_dat_q     <= '0;
            a_user_q    <= 1'b0;
            b_dat_q     <= '0;
            b_last_q    <= 1'b0;
            pair_vld_q  <= 1'b0;
            beat_sel_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_user_q <= hold_user_d;
            pad_q       <= pad_d;
            a_dat_q     <= a_dat_d;
            a_user_q    <= a_user_d;
            b_dat_q     <= b_dat_d;
            b_last_q    <= b_last_d;
            pair_vld_q  <= pair_vld_d;
            beat_sel_q  <= beat_sel_d;
            align_err_q <= align_err_d;
        end
    end

    assign s_axis_video_tready = s_rdy;
    assign m_axis_video_tvalid = pair_vld_q;
    assign m_axis_video_tdata  = beat_sel_q ? b_dat_q : a_dat_q;
    assign m_axis_video_tlast  = beat_sel_q & b_last_q;
    assign m_axis_video_tuser  = !beat_sel_q & a_user_q;
    assign align_err           = align_err_q;

endmodule

// File: tb/tb_ycbcr422_pack.sv
// Bench for ycbcr422_pack: directed vector table plus multi-cycle corner sequences.
// Two instances share stimulus: default rounding and truncating chroma.
// Output beats are collected with optional random backpressure and compared to expectations.
`timescale 1ns/1ps
module tb_ycbcr422_pack;

    logic        clk = 1'b0;
    logic        rstn;
    logic [23:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tuser;
    logic        s_tready, s0_tready;
    logic [15:0] m_tdata, m0_tdata;
    logic        m_tvalid, m0_tvalid, m_tlast, m0_tlast, m_tuser, m0_tuser;
    logic        m_tready;
    logic        align_err, align_err0;

    always #5 clk = ~clk;

    ycbcr422_pack dut (
        .clk(clk), .rstn(rstn),
        .s_axis_video_tdata(s_tdata), .s_axis_video_tvalid(s_tvalid),
        .s_axis_video_tready(s_tready), .s_axis_video_tlast(s_tlast),
        .s_axis_video_tuser(s_tuser),
        .m_axis_video_tdata(m_tdata), .m_axis_video_tvalid(m_tvalid),
        .m_axis_video_tready(m_tready), .m_axis_video_tlast(m_tlast),
        .m_axis_video_tuser(m_tuser), .align_err(align_err)
    );

    ycbcr422_pack #(.CHROMA_ROUND(1'b0)) dut_r0 (
        .clk(clk), .rstn(rstn),
        .s_axis_video_tdata(s_tdata), .s_axis_video_tvalid(s_tvalid),
        .s_axis_video_tready(s0_tready), .s_axis_video_tlast(s_tlast),
        .s_axis_video_tuser(s_tuser),
        .m_axis_video_tdata(m0_tdata), .m_axis_video_tvalid(m0_tvalid),
        .m_axis_video_tready(m_tready), .m_axis_video_tlast(m0_tlast),
        .m_axis_video_tuser(m0_tuser), .align_err(align_err0)
    );

    typedef struct packed {
        logic        user;
        logic        last;
        logic [23:0] dat;   // {Cr, Cb, Y}
    } pix_t;
    typedef logic [17:0] beat_t;  // {user, last, data}

    typedef struct {
        int          np;
        pix_t        px[4];
        int          nb;
        beat_t       bt[4];
        logic [15:0] r0[4];
    } vec_t;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    pix_t  in_q[$];
    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t got0_q[$];
    int    got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic pix_t mkpix(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                                   input logic last, input logic user);
        return {user, last, cr, cb, y};
    endfunction

    function automatic beat_t mkbeat(input logic [15:0] dat, input logic last, input logic user);
        return {user, last, dat};
    endfunction

    function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b, input bit rnd);
        int s;
        s = int'(a) + int'(b) + (rnd ? 1 : 0);
        return 8'(s / 2);
    endfunction

    // Reference: pairs pixels per line, pads odd remainders, restarts on SOF in odd slot
    task automatic model(input bit rnd);
        bit   held;
        pix_t h, p;
        held = 0;
        h = '0;
        exp_q.delete();
        foreach (in_q[i]) begin
            p = in_q[i];
            if (held && p.user) held = 0;
            if (!held) begin
                if (p.last) begin
                    exp_q.push_back(mkbeat({p.dat[15:8], p.dat[7:0]}, 1'b0, p.user));
                    exp_q.push_back(mkbeat({p.dat[23:16], p.dat[7:0]}, 1'b1, 1'b0));
                end else begin
                    h = p;
                    held = 1;
                end
            end else begin
                exp_q.push_back(mkbeat({avg(h.dat[15:8], p.dat[15:8], rnd), h.dat[7:0]}, 1'b0, h.user));
                exp_q.push_back(mkbeat({avg(h.dat[23:16], p.dat[23:16], rnd), p.dat[7:0]}, p.last, 1'b0));
                held = 0;
            end
        end
    endtask

    // Entered and left at posedge+1; drives in_q and collects beats until n_exp arrive
    task automatic run_stream(input int ready_pct, input int gap_pct, input int n_exp);
        int    idx, budget;
        bit    hs, stalled;
        beat_t cur, stall_beat;
        idx = 0;
        stalled = 0;
        stall_beat = '0;
        budget = 20 * n_exp + 200;
        got_q.delete();
        got0_q.delete();
        got_cyc.delete();
        while ((idx < in_q.size() || got_q.size() < n_exp) && budget > 0) begin
            m_tready = ($urandom_range(99) < ready_pct);
            if (!s_tvalid && idx < in_q.size() && $urandom_range(99) >= gap_pct) begin
                s_tvalid = 1'b1;
                {s_tuser, s_tlast, s_tdata} = in_q[idx];
            end
            @(negedge clk);
            hs = s_tvalid && s_tready;
            if (hs) idx++;
            cur = {m_tuser, m_tlast, m_tdata};
            if (stalled) begin
                check("stall_vld", {31'd0, m_tvalid}, 32'd1);
                if (m_tvalid) check("stall_stable", {14'd0, cur}, {14'd0, stall_beat});
            end
            stalled = 0;
            if (m_tvalid) begin
                if (m_tready) begin
                    got_q.push_back(cur);
                    got0_q.push_back({m0_tuser, m0_tlast, m0_tdata});
                    got_cyc.push_back(cyc);
                end else begin
                    stalled = 1;
                    stall_beat = cur;
                end
            end
            @(posedge clk);
            #1;
            if (hs) s_tvalid = 1'b0;
            budget--;
        end
        if (budget == 0) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: got %0d beats expected %0d", got_q.size(), n_exp);
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        check("idle_after", {31'd0, m_tvalid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", name, i), {14'd0, got_q[i]}, {14'd0, exp_q[i]});
    endtask

    vec_t vt[4];

    initial begin
        int len, nlast;

        rstn = 1'b0;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
        m_tready = 1'b0;

        // Directed vectors: {pixels, expected beats (round), expected data (truncate)}
        vt[0].np = 2;
        vt[0].px[0] = mkpix(8'h10, 8'h80, 8'h40, 1'b0, 1'b1);
        vt[0].px[1] = mkpix(8'h20, 8'h81, 8'h50, 1'b0, 1'b0);
        vt[0].nb = 2;
        vt[0].bt[0] = mkbeat(16'h8110, 1'b0, 1'b1);  vt[0].r0[0] = 16'h8010;
        vt[0].bt[1] = mkbeat(16'h4820, 1'b0, 1'b0);  vt[0].r0[1] = 16'h4820;
        vt[1].np = 3;
        vt[1].px[0] = mkpix(8'h01, 8'h10, 8'h20, 1'b0, 1'b0);
        vt[1].px[1] = mkpix(8'h02, 8'h12, 8'h21, 1'b0, 1'b0);
        vt[1].px[2] = mkpix(8'h30, 8'h70, 8'h60, 1'b1, 1'b0);
        vt[1].nb = 4;
        vt[1].bt[0] = mkbeat(16'h1101, 1'b0, 1'b0);  vt[1].r0[0] = 16'h1101;
        vt[1].bt[1] = mkbeat(16'h2102, 1'b0, 1'b0);  vt[1].r0[1] = 16'h2002;
        vt[1].bt[2] = mkbeat(16'h7030, 1'b0, 1'b0);  vt[1].r0[2] = 16'h7030;
        vt[1].bt[3] = mkbeat(16'h6030, 1'b1, 1'b0);  vt[1].r0[3] = 16'h6030;
        vt[2].np = 2;
        vt[2].px[0] = mkpix(8'h40, 8'hFF, 8'h00, 1'b0, 1'b0);
        vt[2].px[1] = mkpix(8'h41, 8'hFE, 8'h01, 1'b1, 1'b0);
        vt[2].nb = 2;
        vt[2].bt[0] = mkbeat(16'hFF40, 1'b0, 1'b0);  vt[2].r0[0] = 16'hFE40;
        vt[2].bt[1] = mkbeat(16'h0141, 1'b1, 1'b0);  vt[2].r0[1] = 16'h0041;
        vt[3].np = 1;
        vt[3].px[0] = mkpix(8'h55, 8'hAA, 8'h33, 1'b1, 1'b1);
        vt[3].nb = 2;
        vt[3].bt[0] = mkbeat(16'hAA55, 1'b0, 1'b1);  vt[3].r0[0] = 16'hAA55;
        vt[3].bt[1] = mkbeat(16'h3355, 1'b1, 1'b0);  vt[3].r0[1] = 16'h3355;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_m_tdata", {16'd0, m_tdata}, 32'd0);
        check("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        check("rst_m_tuser", {31'd0, m_tuser}, 32'd0);
        check("rst_align_err", {31'd0, align_err}, 32'd0);
        check("rst_s_tready", {31'd0, s_tready}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_tready", {31'd0, s_tready}, 32'd1);

        // Table-driven vectors, full rate
        for (int v = 0; v < 4; v++) begin
            in_q.delete();
            exp_q.delete();
            for (int p = 0; p < vt[v].np; p++) in_q.push_back(vt[v].px[p]);
            for (int b = 0; b < vt[v].nb; b++) exp_q.push_back(vt[v].bt[b]);
            run_stream(100, 0, vt[v].nb);
            compare($sformatf("vec%0d", v));
            for (int b = 0; b < vt[v].nb && b < got0_q.size(); b++)
                check($sformatf("vec%0d_trunc[%0d]", v, b), {16'd0, got0_q[b][15:0]}, {16'd0, vt[v].r0[b]});
        end
        check("table_align_err", {31'd0, align_err}, 32'd0);

        // Full-rate 1920-pixel line
        in_q.delete();
        for (int k = 0; k < 1920; k++)
            in_q.push_back(mkpix(8'($urandom), 8'($urandom), 8'($urandom), k == 1919, k == 0));
        model(1'b1);
        run_stream(100, 0, 1920);
        compare("fullrate");
        if (got_cyc.size() == 1920) check("fullrate_span", got_cyc[1919] - got_cyc[0], 32'd1919);
        else check("fullrate_beats", got_cyc.size(), 32'd1920);
        nlast = 0;
        foreach (got_q[i]) if (got_q[i][16]) nlast++;
        check("fullrate_tlast_count", nlast, 32'd1);

        // Random backpressure and input gaps over three lines
        in_q.delete();
        for (int l = 0; l < 3; l++) begin
            len = $urandom_range(13, 5);
            for (int k = 0; k < len; k++)
                in_q.push_back(mkpix(8'($urandom), 8'($urandom), 8'($urandom), k == len - 1, l == 0 && k == 0));
        end
        model(1'b1);
        run_stream(50, 30, exp_q.size());
        compare("random");

        // SOF on pixel 3: pixel 2 is dropped, pixel 3 leads the next pair
        in_q.delete();
        in_q.push_back(mkpix(8'h00, 8'h00, 8'h00, 1'b0, 1'b1));
        in_q.push_back(mkpix(8'h01, 8'h02, 8'h04, 1'b0, 1'b0));
        in_q.push_back(mkpix(8'h02, 8'hEE, 8'hEE, 1'b0, 1'b0));
        in_q.push_back(mkpix(8'h03, 8'h10, 8'h20, 1'b0, 1'b1));
        in_q.push_back(mkpix(8'h04, 8'h12, 8'h22, 1'b1, 1'b0));
        exp_q.delete();
        exp_q.push_back(mkbeat(16'h0100, 1'b0, 1'b1));
        exp_q.push_back(mkbeat(16'h0201, 1'b0, 1'b0));
        exp_q.push_back(mkbeat(16'h1103, 1'b0, 1'b1));
        exp_q.push_back(mkbeat(16'h2104, 1'b1, 1'b0));
        run_stream(100, 0, 4);
        compare("sof");
        check("sof_align_err", {31'd0, align_err}, 32'd1);
        in_q.delete();
        in_q.push_back(mkpix(8'h60, 8'h61, 8'h62, 1'b0, 1'b0));
        in_q.push_back(mkpix(8'h70, 8'h71, 8'h72, 1'b1, 1'b0));
        model(1'b1);
        run_stream(100, 0, 2);
        compare("sof_after");
        check("sof_align_err_sticky", {31'd0, align_err}, 32'd1);

        // Reset with an even pixel held and beat B pending
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        {s_tuser, s_tlast, s_tdata} = mkpix(8'h11, 8'h20, 8'h30, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        {s_tuser, s_tlast, s_tdata} = mkpix(8'h22, 8'h22, 8'h34, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        {s_tuser, s_tlast, s_tdata} = mkpix(8'h33, 8'h99, 8'h99, 1'b0, 1'b0);
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #1;
        check("midpair_b_vld", {31'd0, m_tvalid}, 32'd1);
        check("midpair_b_dat", {16'd0, m_tdata}, 32'h3222);
        rstn = 1'b0;
        #1;
        check("midpair_rst_vld", {31'd0, m_tvalid}, 32'd0);
        check("midpair_rst_tready", {31'd0, s_tready}, 32'd0);
        check("midpair_rst_align", {31'd0, align_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        in_q.delete();
        in_q.push_back(mkpix(8'hA0, 8'h40, 8'h80, 1'b0, 1'b1));
        in_q.push_back(mkpix(8'hB0, 8'h43, 8'h85, 1'b1, 1'b0));
        exp_q.delete();
        exp_q.push_back(mkbeat(16'h42A0, 1'b0, 1'b1));
        exp_q.push_back(mkbeat(16'h83B0, 1'b1, 1'b0));
        run_stream(100, 0, 2);
        compare("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ycbcr422_pack.md
# ycbcr422_pack

Converts the 24-bit 4:4:4 YCbCr AXI4-Stream video produced by the colour-space converter into 16-bit 4:2:2 beats for the Tx path. It takes pixels in pairs, averages the chroma of each pair, and emits two beats per pair: {Cb, Y0} then {Cr, Y1}. The block is full-rate (one pixel in, one beat out per cycle) with backpressure, and preserves SOF (tuser) and EOL (tlast).

## Interface
- CHROMA_ROUND, 1: 1 = chroma average rounds half up, (a+b+1)>>1; 0 = truncates, (a+b)>>1.
- clk  in  1  single clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- s_axis_video_tdata  in  24  pixel data: [7:0]=Y, [15:8]=Cb, [23:16]=Cr.
- s_axis_video_tvalid  in  1  input pixel valid.
- s_axis_video_tready  out  1  input pixel accepted when tvalid and tready are both high.
- s_axis_video_tlast  in  1  last pixel of a line.
- s_axis_video_tuser  in  1  first pixel of a frame (SOF).
- m_axis_video_tdata  out  16  output beat: [7:0]=Y, [15:8]=chroma (Cb on even beat, Cr on odd beat).
- m_axis_video_tvalid  out  1  output beat valid.
- m_axis_video_tready  in  1  downstream ready.
- m_axis_video_tlast  out  1  last beat of a line.
- m_axis_video_tuser  out  1  first beat of a frame.
- align_err  out  1  sticky flag: a pixel was dropped because of SOF misalignment; cleared only by reset.

## Operation
- **Input FSM states:** EVEN (hold register empty) and ODD (even pixel held in Y0/Cb0/Cr0/user0).
- **EVEN state:**
  - s_tready=1.
  - On accept without tlast: capture the pixel, go to ODD.
  - On accept with tlast (odd-length line): load the output pair directly, padding with a duplicate of this pixel. Then Y1=Y0, Cb=Cb0, Cr=Cr0, tlast on beat B. Stay in EVEN.
- **ODD state:**
  - s_tready = !pair_valid || (beat_sel==B && m_tready).
  - On accept: load the output pair and go to EVEN.
    - Beat A = {avg(Cb0,Cb1), Y0} with tuser=user0, tlast=0.
    - Beat B = {avg(Cr0,Cr1), Y1} with tuser=0, tlast=input tlast.
- **SOF realignment:** if a pixel with tuser=1 is accepted in ODD, discard the held even pixel (no output), set align_err, and treat the new pixel as an even pixel (EVEN-state rules, next state ODD).
- **Chroma averaging:** 9-bit sum, result = sum[8:1] after adding CHROMA_ROUND. The result cannot overflow 8 bits.
- **Output pair register:**
  - Holds beats A and B, with pair_valid and beat_sel (A/B).
  - m_tvalid = pair_valid. The outputs show beat A while beat_sel=A, else beat B.
  - A handshake on A advances beat_sel to B.
  - A handshake on B clears pair_valid, unless a new pair is loaded in the same cycle, in which case pair_valid stays 1 and beat_sel returns to A.
  - m_* outputs are driven from registers only; there is no combinational path from s_* to m_*.
- **Reset:** while rstn=0, the FSM is in EVEN, pair_valid=0, beat_sel=A, align_err=0.

## Timing
- **Reset values:**
  - m_axis_video_tvalid=0, m_axis_video_tdata=16'h0000, m_axis_video_tlast=0, m_axis_video_tuser=0, align_err=0.
  - s_axis_video_tready=0 while rstn=0 (gated), and 1 from the first edge after release.
- **Latency:** the odd pixel accepted at edge N produces beat A valid after edge N; beat B follows at the first edge after A's handshake.
- **Throughput:** with m_tready held at 1 and continuous input, one beat per cycle indefinitely with no bubbles. The load of the next pair coincides with beat B's handshake.
- **Backpressure:**
  - A held beat's data, tlast and tuser stay stable while m_tvalid=1 and m_tready=0.
  - s_tready falls in ODD while a pair is pending and B is not completing.
- **Combinational path:** s_tready depends combinationally on m_tready (in ODD only). This is the block's only combinational path.
- **Reset mid-stream:** any held pixel and pending pair are discarded immediately. The first pixel accepted after release is treated as even.

## Test plan
- **Basic pair:** p0=(Y10,Cb80,Cr40,tuser=1), p1=(Y20,Cb81,Cr50) back-to-back, m_tready=1 -> beats 0x8110 (tuser=1) then 0x4820. With CHROMA_ROUND=0 the beats are 0x8010 and 0x4820.
- **Odd-length line:** 3-pixel line where p2=(Y30,Cb70,Cr60,tlast) -> final beats 0x7030 then 0x6030 with tlast=1 on the second. The next line's first pixel is treated as even.
- **Full-rate stream:** 1920-pixel line, continuous valid, m_tready=1 -> exactly 1920 beats in 1920 consecutive cycles, tlast on beat 1920 only.
- **Random backpressure:** m_tready random at 50%, random s_tvalid gaps -> output matches the reference-model sequence, no beat lost or duplicated, data stable while stalled.
- **SOF misalignment:** tuser on pixel 3 of a line -> held pixel 2 is dropped, align_err rises and stays 1, and pixel 3 leads the next pair as beat A with tuser=1.
- **Reset mid-pair:** assert rstn with an even pixel held and beat B pending -> m_tvalid=0 immediately. After release, the next two pixels form a clean pair.
